// File: rtl/uart_ctrl.sv
// Memory-mapped UART controller: CPU data/status registers, TX FIFO paced to the
// transmitter by a request/busy handshake, and an RX FIFO fed by receiver pulses.
module uart_ctrl #(
  parameter int unsigned FIFO_AW = 2,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_bus_ce,
  input  logic              i_bus_we,
  input  logic              i_bus_sel,
  input  logic [15:0]       i_bus_wdata,
  output logic [15:0]       o_bus_rdata,
  output logic              o_send_ready,
  output logic [DATA_W-1:0] o_send_data,
  input  logic              i_send_busy,
  input  logic              i_receive_ready,
  input  logic [DATA_W-1:0] i_receive_data,
  output logic              o_rx_irq
);

  localparam int unsigned       DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]  CNT_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StWait} tx_state_e;

  tx_state_e           r_state;
  logic                r_send_ready;
  logic [DATA_W-1:0]   r_send_data;

  logic [DATA_W-1:0]   r_tx_mem [DEPTH];
  logic [FIFO_AW-1:0]  r_tx_wp, r_tx_rp;
  logic [FIFO_AW:0]    r_tx_cnt;

  logic [DATA_W-1:0]   r_rx_mem [DEPTH];
  logic [FIFO_AW-1:0]  r_rx_wp, r_rx_rp;
  logic [FIFO_AW:0]    r_rx_cnt;

  logic                r_rx_rdy_prev;
  logic                r_rx_overrun;
  logic                r_rx_irq;

  logic w_data_wr, w_data_rd, w_stat_wr;
  logic w_tx_full, w_tx_empty, w_tx_push, w_tx_pop, w_tx_idle;
  logic w_rx_full, w_rx_empty, w_rx_edge, w_rx_push, w_rx_pop, w_ovr_set;
  logic w_unused_wdata;

  assign w_data_wr = i_bus_ce & i_bus_we & ~i_bus_sel;
  assign w_data_rd = i_bus_ce & ~i_bus_we & ~i_bus_sel;
  assign w_stat_wr = i_bus_ce & i_bus_we & i_bus_sel;

  assign w_tx_full  = (r_tx_cnt == CNT_FULL);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_push  = w_data_wr & ~w_tx_full;
  assign w_tx_pop   = (r_state == StIdle) & ~w_tx_empty;
  assign w_tx_idle  = (r_state == StIdle) & w_tx_empty;

  assign w_rx_full  = (r_rx_cnt == CNT_FULL);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_edge  = i_receive_ready & ~r_rx_rdy_prev;
  assign w_rx_pop   = w_data_rd & ~w_rx_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
  assign w_rx_push  = w_rx_edge & (~w_rx_full | w_rx_pop);
  assign w_ovr_set  = w_rx_edge & w_rx_full & ~w_rx_pop;

  // Upper write-data bits have no destination
  assign w_unused_wdata = ^i_bus_wdata;

  assign o_send_ready = r_send_ready;
  assign o_send_data  = r_send_data;
  assign o_rx_irq     = r_rx_irq;

  // Read mux: status word or RX head byte (zero when the RX FIFO is empty)
  always_comb begin
    o_bus_rdata = 16'h0000;
    if (i_bus_sel) begin
      o_bus_rdata = {12'h000, w_tx_idle, r_rx_overrun, ~w_rx_empty, ~w_tx_full};
    end else if (!w_rx_empty) begin
      o_bus_rdata = 16'(r_rx_mem[r_rx_rp]);
    end
  end

  // TX FIFO storage
  always_ff @(posedge i_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= i_bus_wdata[DATA_W-1:0];
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      unique case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  // TX handshake FSM: pop head into send_data, request, wait for busy to rise and fall
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_send_ready <= 1'b0;
      r_send_data  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (!w_tx_empty) begin
            r_send_data  <= r_tx_mem[r_tx_rp];
            r_send_ready <= 1'b1;
            r_state      <= StReq;
          end
        end
        StReq: begin
          if (i_send_busy) begin
            r_send_ready <= 1'b0;
            r_state      <= StWait;
          end
        end
        StWait: begin
          if (!i_send_busy) r_state <= StIdle;
        end
        default: begin
          r_send_ready <= 1'b0;
          r_state      <= StIdle;
        end
      endcase
    end
  end

  // RX FIFO storage
  always_ff @(posedge i_clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp] <= i_receive_data;
  end

  // RX FIFO pointers, occupancy, pulse edge detect, overrun flag and interrupt
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_wp       <= '0;
      r_rx_rp       <= '0;
      r_rx_cnt      <= '0;
      r_rx_rdy_prev <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_rx_irq      <= 1'b0;
    end else begin
      r_rx_rdy_prev <= i_receive_ready;
      r_rx_irq      <= ~w_rx_empty;
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      unique case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
      // A new overrun wins over a same-cycle clear so it is never lost
      if (w_ovr_set) begin
        r_rx_overrun <= 1'b1;
      end else if (w_stat_wr) begin
        r_rx_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl: queue-based reference model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_uart_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ce = 1'b0, we = 1'b0, sel = 1'b0;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic        send_ready;
  logic [7:0]  send_data;
  logic        hold_busy = 1'b0, auto_busy = 1'b0, auto_en = 1'b1;
  logic        send_busy;
  logic        rr = 1'b0;
  logic [7:0]  rd = 8'h00;
  logic        rx_irq;

  int n_total = 0;
  int n_pass  = 0;

  assign send_busy = hold_busy | auto_busy;

  uart_ctrl #(.FIFO_AW(2), .DATA_W(8)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_bus_ce       (ce),
    .i_bus_we       (we),
    .i_bus_sel      (sel),
    .i_bus_wdata    (wdata),
    .o_bus_rdata    (rdata),
    .o_send_ready   (send_ready),
    .o_send_data    (send_data),
    .i_send_busy    (send_busy),
    .i_receive_ready(rr),
    .i_receive_data (rd),
    .o_rx_irq       (rx_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_tx_q[$];
  logic [7:0] m_rx_q[$];
  int         m_phase = 0;  // 0 nothing in flight, 1 requesting, 2 transmitter busy
  logic       m_ready = 1'b0, m_irq = 1'b0, m_ovr = 1'b0, m_rr_prev = 1'b0;
  logic [7:0] m_sdata = 8'h00;
  int         m_tx_n, m_rx_n;
  logic       m_rx_pop, m_rx_edge, m_tx_push;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tx_q.delete();
      m_rx_q.delete();
      m_phase   = 0;
      m_ready   = 1'b0;
      m_irq     = 1'b0;
      m_ovr     = 1'b0;
      m_rr_prev = 1'b0;
      m_sdata   = 8'h00;
    end else begin
      m_tx_n    = m_tx_q.size();
      m_rx_n    = m_rx_q.size();
      m_tx_push = ce && we && !sel && (m_tx_n < 4);
      m_rx_pop  = ce && !we && !sel && (m_rx_n > 0);
      m_rx_edge = rr && !m_rr_prev;
      if (m_phase == 0 && m_tx_n > 0) begin
        m_sdata = m_tx_q.pop_front();
        m_ready = 1'b1;
        m_phase = 1;
      end else if (m_phase == 1 && send_busy) begin
        m_ready = 1'b0;
        m_phase = 2;
      end else if (m_phase == 2 && !send_busy) begin
        m_phase = 0;
      end
      if (m_tx_push) m_tx_q.push_back(wdata[7:0]);
      if (m_rx_pop) void'(m_rx_q.pop_front());
      if (ce && we && sel) m_ovr = 1'b0;
      if (m_rx_edge) begin
        if (m_rx_n < 4 || m_rx_pop) m_rx_q.push_back(rd);
        else m_ovr = 1'b1;
      end
      m_irq     = (m_rx_n != 0);
      m_rr_prev = rr;
    end
  end

  function automatic logic [15:0] m_rdata();
    logic idle;
    idle = (m_phase == 0) && (m_tx_q.size() == 0);
    if (sel) return {12'h000, idle, m_ovr, m_rx_q.size() != 0, m_tx_q.size() < 4};
    if (m_rx_q.size() != 0) return {8'h00, m_rx_q[0]};
    return 16'h0000;
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("send_ready", 32'(send_ready), 32'(m_ready));
    check("send_data", 32'(send_data), 32'(m_sdata));
    check("rx_irq", 32'(rx_irq), 32'(m_irq));
    check("bus_rdata", 32'(rdata), 32'(m_rdata()));
  end

  // Log of each distinct send_ready assertion and its byte
  logic       mon_prev = 1'b0;
  logic [7:0] sent_log[$];
  always @(negedge clk) begin
    if (send_ready && !mon_prev) sent_log.push_back(send_data);
    mon_prev <= send_ready;
  end

  // Transmitter stand-in: busy for 4 cycles after each observed request
  initial begin
    forever begin
      @(posedge clk); #1;
      if (auto_en && send_ready && !auto_busy) begin
        auto_busy = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        auto_busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic s, input logic [15:0] d);
    ce = 1'b1; we = 1'b1; sel = s; wdata = d;
    tick();
    ce = 1'b0; we = 1'b0; sel = 1'b0;
  endtask

  task automatic bus_read(input logic s, output logic [15:0] v);
    ce = 1'b1; we = 1'b0; sel = s;
    @(negedge clk);
    v = rdata;
    tick();
    ce = 1'b0; sel = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rr = 1'b1; rd = b;
    tick(); tick();
    rr = 1'b0;
    tick();
  endtask

  task automatic wait_sent(input int n, input int budget);
    int c;
    c = 0;
    while (sent_log.size() < n && c < budget) begin
      tick();
      c++;
    end
    check("sent_count_reached", 32'(sent_log.size()), 32'(n));
  endtask

  logic [15:0] v;
  logic [7:0]  exp_b;

  initial begin
    #2 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    bus_read(1'b1, v);
    check("reset_status", 32'(v), 32'h0009);
    check("reset_rx_irq", 32'(rx_irq), 32'h0);
    check("reset_send_ready", 32'(send_ready), 32'h0);

    // Two bytes back-to-back through the handshake
    bus_write(1'b0, 16'h0041);
    bus_write(1'b0, 16'h0042);
    wait_sent(2, 100);
    repeat (10) tick();
    check("tx_byte0", 32'(sent_log[0]), 32'h41);
    check("tx_byte1", 32'(sent_log[1]), 32'h42);
    check("tx_starts", 32'(sent_log.size()), 32'd2);
    bus_read(1'b1, v);
    check("tx_done_status", 32'(v), 32'h0009);

    // Fill the TX FIFO while the transmitter is held busy
    hold_busy = 1'b1;
    for (int i = 1; i <= 5; i++) bus_write(1'b0, 16'(i));
    bus_read(1'b1, v);
    check("tx_full_status", 32'(v), 32'h0000);
    bus_write(1'b0, 16'h0006);
    bus_read(1'b1, v);
    check("tx_drop_status", 32'(v), 32'h0000);
    hold_busy = 1'b0;
    wait_sent(7, 300);
    repeat (12) tick();
    check("tx_no_extra", 32'(sent_log.size()), 32'd7);
    for (int i = 2; i < 7; i++) begin
      exp_b = 8'(i - 1);
      check("tx_order", 32'(sent_log[i]), 32'(exp_b));
    end

    // Two RX pulses
    rx_pulse(8'hA5);
    rx_pulse(8'h5A);
    check("rx_irq_set", 32'(rx_irq), 32'h1);
    bus_read(1'b1, v);
    check("rx_status", 32'(v), 32'h000B);
    bus_read(1'b0, v);
    check("rx_read0", 32'(v), 32'h00A5);
    bus_read(1'b0, v);
    check("rx_read1", 32'(v), 32'h005A);
    tick();
    @(negedge clk);
    check("rx_irq_clear", 32'(rx_irq), 32'h0);
    tick();
    bus_read(1'b0, v);
    check("rx_read_empty", 32'(v), 32'h0000);

    // Overrun: five pulses into a four-entry FIFO
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    rx_pulse(8'h33);
    rx_pulse(8'h44);
    rx_pulse(8'h55);
    bus_read(1'b1, v);
    check("ovr_status", 32'(v), 32'h000F);
    bus_write(1'b1, 16'hFFFF);
    bus_read(1'b1, v);
    check("ovr_cleared", 32'(v), 32'h000B);
    for (int i = 1; i <= 4; i++) begin
      bus_read(1'b0, v);
      exp_b = 8'(i * 8'h11);
      check("ovr_kept", 32'(v), 32'(exp_b));
    end
    bus_read(1'b0, v);
    check("ovr_empty", 32'(v), 32'h0000);

    // Reset while a request is pending
    auto_en = 1'b0;
    bus_write(1'b0, 16'h0077);
    bus_write(1'b0, 16'h0088);
    tick();
    check("req_pending", 32'(send_ready), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_send_ready", 32'(send_ready), 32'h0);
    sel = 1'b1;
    #1;
    check("rst_status", 32'(rdata), 32'h0009);
    sel = 1'b0;
    tick();
    rst_n = 1'b1;
    auto_en = 1'b1;
    tick();
    bus_read(1'b1, v);
    check("post_rst_status", 32'(v), 32'h0009);
    check("post_rst_send_data", 32'(send_data), 32'h00);
    check("post_rst_send_ready", 32'(send_ready), 32'h0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
